// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: FSM state encoding and
// the line levels used for idle, start and stop bits.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage : serial_pkg

// File: rtl/serial_tx_piso_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and pulses
// tick on the last cycle of each period. Shared with the matching receiver.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold at zero while cleared, wrap at the end of a bit, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Cycle counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST_CNT);

endmodule : bit_timer

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter. Frames a DATA_BITS word as
// start bit, data LSB first, stop bit; each bit lasts CLKS_PER_BIT cycles.
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 start,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_e              state_q;
    tx_state_e              state_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [BW-1:0]          bit_cnt_q;
    logic [BW-1:0]          bit_cnt_d;
    logic                   tx_q;
    logic                   tx_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   done_q;
    logic                   done_d;

    logic                   timer_clear_s;
    logic                   tick_s;
    logic [DATA_BITS-1:0]   shifted_s;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear_s),
        .tick  (tick_s)
    );

    // Shift register after one right shift; bit 0 is the next data bit on the line.
    always_comb begin
        shifted_s = shift_q >> 1;
    end

    // Frame sequencing: next state, shift/bit counter updates and registered output values.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timer_clear_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Timer is held at zero so the start bit gets a full period.
                timer_clear_s = 1'b1;
                if (start) begin
                    shift_d   = data_in;
                    bit_cnt_d = {BW{1'b0}};
                    state_d   = ST_START;
                    tx_d      = START_LEVEL;
                    busy_d    = 1'b1;
                end else begin
                    tx_d      = IDLE_LEVEL;
                    busy_d    = 1'b0;
                end
            end

            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    tx_d    = START_LEVEL;
                end
            end

            ST_DATA: begin
                if (tick_s) begin
                    shift_d = shifted_s;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_STOP;
                        bit_cnt_d = {BW{1'b0}};
                        tx_d      = STOP_LEVEL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shifted_s[0];
                    end
                end else begin
                    tx_d = shift_q[0];
                end
            end

            ST_STOP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tx_d    = IDLE_LEVEL;
                end else begin
                    tx_d    = STOP_LEVEL;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = {BW{1'b0}};
                tx_d      = IDLE_LEVEL;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset overrides any in-flight frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= {DATA_BITS{1'b0}};
            bit_cnt_q <= {BW{1'b0}};
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : serial_tx_piso

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso: an 8-bit / 4-clock instance and a
// 1-bit / 2-clock corner instance, checked cycle by cycle against
// hand-written frame patterns. Outputs are sampled 1 time unit after each edge.
module tb_serial_tx_piso;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b1;
    logic       start_a = 1'b0;
    logic [7:0] data_a  = 8'h00;
    logic       tx_a, busy_a, done_a;

    logic       reset_b = 1'b1;
    logic       start_b = 1'b0;
    logic [0:0] data_b  = 1'b0;
    logic       tx_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    serial_tx_piso #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset_a), .data_in(data_a), .start(start_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    serial_tx_piso #(.DATA_BITS(1), .CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .reset(reset_b), .data_in(data_b), .start(start_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({tx_a, busy_a, done_a} !== 3'b100) begin
                bad++; $display("FAIL reset_a cyc=%0d: got %b want 100", i, {tx_a, busy_a, done_a});
            end
            total++;
            if ({tx_b, busy_b, done_b} !== 3'b100) begin
                bad++; $display("FAIL reset_b cyc=%0d: got %b want 100", i, {tx_b, busy_b, done_b});
            end
        end
        reset_a = 1'b0; reset_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            total++;
            if ({tx_a, busy_a, done_a, tx_b, busy_b, done_b} !== 6'b100100) begin
                bad++; $display("FAIL idle cyc=%0d: got %b want 100100", i, {tx_a, busy_a, done_a, tx_b, busy_b, done_b});
            end
        end
    endtask

    task automatic test_reset_and_start();
        reset_a = 1'b1; start_a = 1'b1; data_a = 8'hFF;
        step();
        total++;
        if ({tx_a, busy_a, done_a} !== 3'b100) begin
            bad++; $display("FAIL reset_wins: got %b want 100", {tx_a, busy_a, done_a});
        end
        reset_a = 1'b0; start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({tx_a, busy_a, done_a} !== 3'b100) begin
                bad++; $display("FAIL reset_wins_idle cyc=%0d: got %b want 100", i, {tx_a, busy_a, done_a});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] pat;
        logic [2:0] exp;
        int busy_cnt;
        int done_cnt;
        pat = 10'b0101001011;   // A5 framed: 0,1,0,1,0,0,1,0,1,1
        busy_cnt = 0; done_cnt = 0;
        data_a = 8'hA5; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c < 40)       exp = {pat[9 - c / 4], 2'b10};
            else if (c == 40) exp = 3'b101;
            else              exp = 3'b100;
            total++;
            if ({tx_a, busy_a, done_a} !== exp) begin
                bad++; $display("FAIL single_frame c=%0d: got %b want %b", c, {tx_a, busy_a, done_a}, exp);
            end
            busy_cnt += int'(busy_a);
            done_cnt += int'(done_a);
            step();
        end
        total++;
        if (busy_cnt != 40) begin
            bad++; $display("FAIL single_busy_len: got %0d want 40", busy_cnt);
        end
        total++;
        if (done_cnt != 1) begin
            bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_busy_lockout();
        logic [9:0] pat;
        logic [2:0] exp;
        pat = 10'b0001111001;   // 3C framed: 0,0,0,1,1,1,1,0,0,1
        data_a = 8'h3C; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c < 40)       exp = {pat[9 - c / 4], 2'b10};
            else if (c == 40) exp = 3'b101;
            else              exp = 3'b100;
            total++;
            if ({tx_a, busy_a, done_a} !== exp) begin
                bad++; $display("FAIL lockout c=%0d: got %b want %b", c, {tx_a, busy_a, done_a}, exp);
            end
            start_a = (c == 5 || c == 20);
            data_a  = start_a ? 8'hFF : 8'h3C;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] pat1;
        logic [9:0] pat2;
        logic [2:0] exp;
        int done_cnt;
        pat1 = 10'b0100000001;  // 01 framed
        pat2 = 10'b0000000011;  // 80 framed
        done_cnt = 0;
        data_a = 8'h01; start_a = 1'b1;
        step();
        for (int c = 0; c < 83; c++) begin
            if (c < 40)       exp = {pat1[9 - c / 4], 2'b10};
            else if (c == 40) exp = 3'b101;
            else if (c < 81)  exp = {pat2[9 - (c - 41) / 4], 2'b10};
            else if (c == 81) exp = 3'b101;
            else              exp = 3'b100;
            total++;
            if ({tx_a, busy_a, done_a} !== exp) begin
                bad++; $display("FAIL back_to_back c=%0d: got %b want %b", c, {tx_a, busy_a, done_a}, exp);
            end
            done_cnt += int'(done_a);
            if (c == 40) data_a = 8'h80;
            if (c == 81) start_a = 1'b0;
            step();
        end
        total++;
        if (done_cnt != 2) begin
            bad++; $display("FAIL back_to_back_done_cnt: got %0d want 2", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] pat;
        logic [2:0] exp;
        int done_cnt;
        pat = 10'b0101010101;   // 55 framed
        done_cnt = 0;
        data_a = 8'h55; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            exp = {pat[9 - c / 4], 2'b10};
            total++;
            if ({tx_a, busy_a, done_a} !== exp) begin
                bad++; $display("FAIL mid_reset_pre c=%0d: got %b want %b", c, {tx_a, busy_a, done_a}, exp);
            end
            if (c == 17) reset_a = 1'b1;
            step();
        end
        total++;
        if ({tx_a, busy_a, done_a} !== 3'b100) begin
            bad++; $display("FAIL mid_reset_after: got %b want 100", {tx_a, busy_a, done_a});
        end
        reset_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            done_cnt += int'(done_a);
            total++;
            if ({tx_a, busy_a, done_a} !== 3'b100) begin
                bad++; $display("FAIL mid_reset_idle cyc=%0d: got %b want 100", i, {tx_a, busy_a, done_a});
            end
        end
        total++;
        if (done_cnt != 0) begin
            bad++; $display("FAIL mid_reset_no_done: got %0d want 0", done_cnt);
        end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 0; c < 42; c++) begin
            if (c < 40)       exp = {pat[9 - c / 4], 2'b10};
            else if (c == 40) exp = 3'b101;
            else              exp = 3'b100;
            total++;
            if ({tx_a, busy_a, done_a} !== exp) begin
                bad++; $display("FAIL mid_reset_refrm c=%0d: got %b want %b", c, {tx_a, busy_a, done_a}, exp);
            end
            step();
        end
    endtask

    task automatic test_param_corner();
        logic [5:0] pats [2];
        logic [2:0] exp;
        int busy_cnt;
        pats[0] = 6'b000011;    // data 0: 0,0,0,0,1,1
        pats[1] = 6'b001111;    // data 1: 0,0,1,1,1,1
        for (int f = 0; f < 2; f++) begin
            busy_cnt = 0;
            data_b = (f == 1) ? 1'b1 : 1'b0;
            start_b = 1'b1;
            step();
            start_b = 1'b0;
            for (int c = 0; c < 9; c++) begin
                if (c < 6)       exp = {pats[f][5 - c], 2'b10};
                else if (c == 6) exp = 3'b101;
                else             exp = 3'b100;
                total++;
                if ({tx_b, busy_b, done_b} !== exp) begin
                    bad++; $display("FAIL corner f=%0d c=%0d: got %b want %b", f, c, {tx_b, busy_b, done_b}, exp);
                end
                busy_cnt += int'(busy_b);
                step();
            end
            total++;
            if (busy_cnt != 6) begin
                bad++; $display("FAIL corner_busy_len f=%0d: got %0d want 6", f, busy_cnt);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_reset_and_start();
        test_single_frame();
        test_busy_lockout();
        test_back_to_back();
        test_reset_mid_frame();
        test_param_corner();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_tx_piso
